// File: rtl/nonogram_pkg.sv
// Constants and types shared by the nonogram parser, solver and serializer.
package nonogram_pkg;

    localparam int unsigned MAX_DIM = 11;
    localparam int unsigned DIM_W   = $clog2(MAX_DIM + 1);
    localparam int unsigned HDR_LEN = 2;
    localparam int unsigned TRL_LEN = 1;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StFinish
    } ser_state_e;

endpackage

// File: rtl/solution_serializer.sv
// Snapshots a solved board on start and streams it to uart_tx as a framed packet:
// n, m, packed rows (LSB = lowest column), then an XOR checksum of all preceding bytes.
module solution_serializer #(
    parameter int unsigned MAX_DIM = nonogram_pkg::MAX_DIM,
    parameter int unsigned DIM_W   = $clog2(MAX_DIM + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [MAX_DIM*MAX_DIM-1:0] board,
    input  logic [DIM_W-1:0]           n,
    input  logic [DIM_W-1:0]           m,
    input  logic                       tx_done,
    output logic                       tx_valid,
    output logic [7:0]                 tx_byte,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    import nonogram_pkg::*;

    localparam int unsigned BPR_MAX = (MAX_DIM + 7) / 8;
    localparam int unsigned IDX_W   = $clog2(HDR_LEN + TRL_LEN + MAX_DIM * BPR_MAX);
    localparam int unsigned ROW_W   = DIM_W + 1;
    localparam int unsigned COL_W   = $clog2(BPR_MAX + 1);
    // Eight spare zero bits let the last row's upper byte be part-selected without overrun.
    localparam int unsigned BRD_W   = MAX_DIM * MAX_DIM + 8;
    localparam int unsigned OFF_W   = $clog2(BRD_W);

    ser_state_e       state_q, state_d;
    logic [BRD_W-1:0] board_q, board_d;
    logic [DIM_W-1:0] n_q, n_d, m_q, m_d;
    logic [COL_W-1:0] bpr_q, bpr_d, col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d;
    logic [7:0]       csum_q, csum_d, tx_byte_q, tx_byte_d;
    logic             tx_valid_q, tx_valid_d, busy_q, busy_d;
    logic             done_q, done_d, err_q, err_d;
    logic [7:0]       cur_byte, col_mask;
    logic [OFF_W-1:0] row_off;
    logic             dims_ok, is_row;

    assign dims_ok = (n != '0) && (32'(n) <= MAX_DIM) && (m != '0) && (32'(m) <= MAX_DIM);
    assign is_row  = (idx_q >= IDX_W'(HDR_LEN)) && (idx_q != last_q);

    always_comb begin
        row_off = OFF_W'(row_q) * OFF_W'(MAX_DIM) + OFF_W'({col_q, 3'b000});
        for (int i = 0; i < 8; i++) begin
            col_mask[i] = ((32'(col_q) << 3) + 32'(i)) < 32'(m_q);
        end
        if (idx_q == '0) begin
            cur_byte = 8'(n_q);
        end else if (idx_q == IDX_W'(1)) begin
            cur_byte = 8'(m_q);
        end else if (idx_q == last_q) begin
            cur_byte = csum_q;
        end else begin
            cur_byte = board_q[row_off +: 8] & col_mask;
        end
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        n_d        = n_q;
        m_d        = m_q;
        bpr_d      = bpr_q;
        last_d     = last_q;
        idx_d      = idx_q;
        row_d      = row_q;
        col_d      = col_q;
        csum_d     = csum_q;
        tx_valid_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (dims_ok) begin
                        board_d = {8'h00, board};
                        n_d     = n;
                        m_d     = m;
                        bpr_d   = COL_W'((32'(m) + 32'd7) >> 3);
                        last_d  = IDX_W'(HDR_LEN + 32'(n) * ((32'(m) + 32'd7) >> 3) + TRL_LEN - 1);
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        csum_d  = '0;
                        state_d = StSend;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSend: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = cur_byte;
                busy_d     = 1'b1;
                if (idx_q != last_q) begin
                    csum_d = csum_q ^ cur_byte;
                end
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    if (idx_q == last_q) begin
                        state_d = StFinish;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (is_row) begin
                            if (col_q == bpr_q - COL_W'(1)) begin
                                col_d = '0;
                                row_d = row_q + ROW_W'(1);
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                        state_d = StSend;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            board_q    <= '0;
            n_q        <= '0;
            m_q        <= '0;
            bpr_q      <= '0;
            last_q     <= '0;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            csum_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            n_q        <= n_d;
            m_q        <= m_d;
            bpr_q      <= bpr_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            csum_q     <= csum_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_byte  = tx_byte_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/solution_serializer.md
# solution_serializer

Downstream stage of the solver, occupying the TRANSMIT step of the top-level flow. Snapshots a solved n×m board bitmap on a start pulse and streams it, one byte at a time, into `uart_tx`. It follows that module's `axiiv`/`done` handshake, and the result is a framed packet of header, packed rows and an XOR checksum. It pulses `done` when the last byte has left the UART.

## Interface

Parameters:
- `MAX_DIM`, default 11: maximum rows and columns of the board.
- `DIM_W`, default `$clog2(MAX_DIM+1)` (4): width of the `n` and `m` inputs.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: single-cycle request to send the presented board.
- `board`  in  MAX_DIM*MAX_DIM: solved cells; bit `r*MAX_DIM+c` is row r, column c; 1 means filled.
- `n`  in  DIM_W: row count.
- `m`  in  DIM_W: column count.
- `tx_done`  in  1: `uart_tx` `done`, a one-cycle pulse when the current byte is fully shifted out.
- `tx_valid`  out  1: to `uart_tx` `axiiv`; one-cycle pulse per byte.
- `tx_byte`  out  8: to `uart_tx` `axiid`; valid while `tx_valid` is high.
- `busy`  out  1: high from the cycle after an accepted start until `done`.
- `done`  out  1: one-cycle pulse when the packet has completed.
- `err`  out  1: one-cycle pulse when a start is rejected for bad dimensions.

## Operation

Packet format, in order:
- byte 0 = `n`; byte 1 = `m`, both zero-extended to 8 bits.
- Then for r = 0..n-1, B = ceil(m/8) bytes per row. In byte k of row r, bit i is column 8k+i. Bits for columns ≥ m are 0.
- Final byte = XOR of every preceding byte in the packet.
- Total length = 3 + n·B bytes; the maximum is 25 bytes for an 11×11 board.

States:
- IDLE: on `start`, check the dimensions.
  - If 1 ≤ n ≤ MAX_DIM and 1 ≤ m ≤ MAX_DIM: latch `board`, `n`, `m`; clear the checksum, byte index and row counter; go to SEND.
  - Otherwise pulse `err` and remain in IDLE.
- SEND: drive `tx_valid`=1 and `tx_byte` for exactly one cycle; fold the byte into the checksum unless it is the checksum byte itself; go to WAIT.
- WAIT: hold until `tx_done`. Then go to SEND if bytes remain; otherwise go to FINISH.
- FINISH: pulse `done`; go to IDLE.

Rules:
- All inputs are sampled only at acceptance. Later changes to `board`, `n` or `m` do not affect a packet in flight.
- `start` while `busy` is ignored: no queueing, no `err`.
- `tx_done` outside WAIT is ignored.
- Column counter and row counter are widened so that n·B needs no wrap handling. Byte index width is `$clog2(3+MAX_DIM*ceil(MAX_DIM/8))`.

## Timing

- Reset (async, `rst_n`=0): state IDLE; `tx_valid`, `tx_byte`, `busy`, `done`, `err` all 0; checksum and counters 0. Reset mid-packet aborts silently with no `done`. Resetting `uart_tx` is the top level's responsibility.
- Outputs are registered.
- `start` sampled at edge k: `tx_valid` is high in the cycle after edge k+1 with byte 0, and `busy` goes high at the same time.
- `tx_done` sampled at edge j: the next `tx_valid` is high after edge j+1, giving one-cycle turnaround.
- Last `tx_done` at edge j: `done` is high after edge j+1 and `busy` falls in the same cycle.
- A new `start` is accepted in the cycle `done` is high, i.e. back-to-back packets.
- `err` is high in the cycle after the rejected `start`.

## Structure

- Shared package `nonogram_pkg`: `MAX_DIM`, `DIM_W`, the state enum (IDLE/SEND/WAIT/FINISH), header length (2) and trailer length (1). Parser and solver import the same constants.
- No sub-module. Row-byte selection is an indexed part-select on the latched board, masked by `m`, and stays inline.

## Test plan

- 2×3 board, row0 = cols 0 and 2, row1 = col 1; model `tx_done` 10 cycles after each `tx_valid` → bytes 0x02, 0x03, 0x05, 0x02, 0x06, then `done`.
- 11×11 all ones → 25 bytes: 0x0B, 0x0B, then eleven pairs of (0xFF, 0x07), then checksum 0xF8; padding bits are 0.
- `start` with n = 0, and separately with m = 12 → `err` pulses once, no `tx_valid`, `busy` stays 0.
- `start` re-pulsed mid-packet, and `board` changed after acceptance → packet is identical to the first one; no second packet is sent.
- `rst_n` low while in WAIT after byte 3 → all outputs 0 asynchronously; a fresh `start` after release sends the full packet from byte 0.
- Spurious `tx_done` while in IDLE or SEND, plus a `start` in the `done` cycle → spurious pulses are ignored; the second packet's byte 0 appears 1 cycle after acceptance.
